pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline stage register with a ready/valid handshake and a 2-entry skid buffer. It replaces the fixed-field, always-enabled inter-stage registers (IF/ID through MEM/WB) with one generic block. It adds back-pressure (stall), synchronous flush with bubble insertion, and a saturating stall counter for performance monitoring. One instance sits between each pair of pipeline stages. The caller packs the stage fields into `in_data`.

## Interface

Parameters:
- `DATA_W`, default 71: total payload width. The default is 2 control bits, two 32-bit data words and a 5-bit register number.
- `CTRL_W`, default 2: number of payload LSBs that are control/write-enable bits. They are forced to 0 whenever `out_valid`=0. Range 0..`DATA_W`.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clock` input 1: single clock; all state updates on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream stage presents a valid payload.
- `in_ready` output 1: block can accept a payload this cycle. Registered.
- `in_data` input `DATA_W`: upstream payload.
- `out_valid` output 1: `out_data` holds a valid payload.
- `out_ready` input 1: downstream stage consumes `out_data` this cycle.
- `out_data` output `DATA_W`: payload to the downstream stage.
- `flush` input 1: synchronous flush; discards all held entries.
- `occupancy` output 2: number of held entries (0, 1, 2).
- `stall_cnt` output `CNT_W`: saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation

- Storage:
  - `main` register: drives `out_data`.
  - `skid` register: catches the payload accepted in the cycle downstream stalls.
- Transfers:
  - Input transfer = `in_valid` & `in_ready`.
  - Output transfer = `out_valid` & `out_ready`.
- States and transitions. A cell lists the next state and the action:
  - EMPTY (occ 0):
    - Input transfer: `main`<=`in_data` → ONE.
    - Otherwise: stay EMPTY.
  - ONE (occ 1):
    - Input transfer and output transfer: `main`<=`in_data`, stay ONE.
    - Input transfer only: `skid`<=`in_data` → FULL.
    - Output transfer only: → EMPTY.
    - Neither: hold.
  - FULL (occ 2):
    - Input transfer is impossible because `in_ready`=0.
    - Output transfer: `main`<=`skid` → ONE.
    - Otherwise: hold.
- Outputs derived from state:
  - `in_ready` is registered and equals 1 in the cycle after any state other than FULL is entered. There is no combinational path from `out_ready` to `in_ready`.
  - `out_valid` = (state ≠ EMPTY), driven from the state register.
- `out_data`:
  - Equals `main`.
  - Bits [`CTRL_W`-1:0] are masked to 0 when `out_valid`=0, so a bubble never asserts write enables downstream.
- `flush` has highest priority. On a rising edge with `flush`=1:
  - State goes to EMPTY.
  - Any input transfer in that cycle is dropped. The handshake completes but the data is discarded.
  - `main` and `skid` contents are don't-care, but the control field stays masked.
  - `in_ready`=1 next cycle.
- `stall_cnt`:
  - Increments on each edge where `out_valid`=1 and `out_ready`=0.
  - Saturates at 2^`CNT_W`-1.
  - Unaffected by `flush`; cleared only by reset.
- Ordering: payloads leave in the order accepted; no duplication, no loss except by flush.

## Timing

- Reset (`resetn`=0, asynchronous): state EMPTY, `main`=0, `skid`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `occupancy`=0, `stall_cnt`=0.
- First rising edge after `resetn` deasserts: `in_ready` becomes 1. Reset asserted mid-operation discards everything immediately, without waiting for a clock edge.
- Latency: input transfer at edge N → `out_valid`=1 with that payload after edge N.
- Throughput: 1 payload/cycle sustained while `out_ready`=1.
- Back-pressure: after a stall, at most one more payload is accepted (into `skid`). `in_ready` falls after the edge that fills `skid`.
- Simultaneous flush and transfer: flush wins on both sides. Nothing is delivered downstream from that edge onward until a new input transfer.
- `stall_cnt` at maximum with a further stall: holds its value; no wrap.

## Test plan

1. Reset, then stream 0x1..0x8 with `in_valid`=1 and `out_ready`=1 every cycle → 8 consecutive outputs 0x1..0x8, each one cycle after acceptance; `in_ready` stays 1; `stall_cnt`=0.
2. Stream A, B, C; hold `out_ready`=0 for 3 cycles starting when A is on the output → occupancy reaches 2 (A in `main`, B in `skid`) and `in_ready`=0. C is accepted only after `out_ready` returns. Output order is A, B, C. `stall_cnt`=3.
3. FULL state with `flush`=1 while `in_valid`=1 → next cycle `out_valid`=0, occupancy 0, `out_data`[1:0]=0, `in_ready`=1; the dropped payloads never appear.
4. `CNT_W`=4 with `out_ready` held 0 for 20 cycles while valid → `stall_cnt`=15 and holds at 15.
5. Assert `resetn`=0 asynchronously mid-stream between clock edges → all outputs 0 immediately. `in_ready`=0 until the first edge after release, then 1.
6. `CTRL_W`=2 with `in_data`=0x3 followed by idle → after consumption, `out_valid`=0 and `out_data`[1:0]=0 while the upper bits are don't-care.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic pipeline stage register
// ready/valid handshake, 2-entry skid, flush, stall counter
module pipe_skid_reg #(
  parameter int DATA_W = 71,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [DATA_W-1:0]  r_main;
  logic [DATA_W-1:0]  r_skid;
  logic               r_in_ready;
  logic [CNT_W-1:0]   r_stall;

  logic               w_out_valid;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_ld_main_in;
  logic               w_ld_main_skid;
  logic               w_ld_skid;
  logic [DATA_W-1:0]  w_out_data;

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_xfer   = in_valid & r_in_ready;
  assign w_out_xfer  = w_out_valid & out_ready;

  // next-state and storage load selects; flush overrides all
  always_comb begin
    w_next         = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_ld_main_in = 1'b1;
            w_next       = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_ld_main_in = 1'b1;
          end else if (w_in_xfer) begin
            w_ld_skid = 1'b1;
            w_next    = S_FULL;
          end else if (w_out_xfer) begin
            w_next = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            w_ld_main_skid = 1'b1;
            w_next         = S_ONE;
          end
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // state register and registered in_ready
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_FULL);
    end
  end

  // payload storage: main feeds the output, skid absorbs one stall
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in)
        r_main <= in_data;
      else if (w_ld_main_skid)
        r_main <= r_skid;
      if (w_ld_skid)
        r_skid <= in_data;
    end
  end

  // saturating count of stalled output cycles
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_stall <= '0;
    else if (w_out_valid && !out_ready && (r_stall != {CNT_W{1'b1}}))
      r_stall <= r_stall + 1'b1;
  end

  // bubbles never carry write enables downstream
  always_comb begin
    w_out_data = r_main;
    for (int i = 0; i < CTRL_W; i++)
      w_out_data[i] = r_main[i] & w_out_valid;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_data;
  assign occupancy = r_state;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed checks of pipe_skid_reg
// main instance uses defaults, second uses CNT_W=4
module tb_pipe_skid_reg;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic [70:0] in_data;
  logic        out_ready;
  logic        flush;

  logic        in_ready;
  logic        out_valid;
  logic [70:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [70:0] out_data4;
  logic [1:0]  occupancy4;
  logic [3:0]  stall_cnt4;

  int total;
  int bad;

  pipe_skid_reg u_dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  pipe_skid_reg #(.CNT_W(4)) u_dut4 (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in_data   (in_data),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4),
    .flush     (flush),
    .occupancy (occupancy4),
    .stall_cnt (stall_cnt4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #7;
    total++;
    if (out_valid !== 1'b0 || out_data !== 71'd0 || occupancy !== 2'd0) begin
      bad++;
      $display("FAIL rst_out v=%b d=%0h occ=%0d exp 0 0 0",
               out_valid, out_data, occupancy);
    end
    total++;
    if (in_ready !== 1'b0 || stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rst_rdy rdy=%b cnt=%0d exp 0 0", in_ready, stall_cnt);
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rdy_pre_edge got=%b exp=0", in_ready);
    end
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rdy_post_edge got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      in_valid  = 1'b1;
      in_data   = 71'(i);
      out_ready = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 71'(i) || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream%0d v=%b d=%0h rdy=%b exp 1 %0h 1",
                 i, out_valid, out_data, in_ready, i);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL stream_end v=%b occ=%0d cnt=%0d exp 0 0 0",
               out_valid, occupancy, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    in_valid  = 1'b1;
    in_data   = 71'h0A0;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_data !== 71'h0A0 || occupancy !== 2'd1) begin
      bad++;
      $display("FAIL bp_a d=%0h occ=%0d exp a0 1", out_data, occupancy);
    end
    in_data   = 71'h0B0;
    out_ready = 1'b0;
    tick();
    total++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 71'h0A0) begin
      bad++;
      $display("FAIL bp_full occ=%0d rdy=%b d=%0h exp 2 0 a0",
               occupancy, in_ready, out_data);
    end
    in_data = 71'h0C0;
    tick();
    tick();
    total++;
    if (occupancy !== 2'd2 || stall_cnt !== 16'd3 || out_data !== 71'h0A0) begin
      bad++;
      $display("FAIL bp_hold occ=%0d cnt=%0d d=%0h exp 2 3 a0",
               occupancy, stall_cnt, out_data);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_data !== 71'h0B0 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_b d=%0h occ=%0d rdy=%b exp b0 1 1",
               out_data, occupancy, in_ready);
    end
    tick();
    total++;
    if (out_data !== 71'h0C0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_c d=%0h v=%b exp c0 1", out_data, out_valid);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'd3) begin
      bad++;
      $display("FAIL bp_end v=%b cnt=%0d exp 0 3", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush();
    in_valid  = 1'b1;
    in_data   = 71'h0D3;
    out_ready = 1'b0;
    tick();
    in_data = 71'h0E3;
    tick();
    total++;
    if (occupancy !== 2'd2) begin
      bad++;
      $display("FAIL fl_full occ=%0d exp 2", occupancy);
    end
    in_data = 71'h0F3;
    flush   = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 ||
        out_data[1:0] !== 2'b00 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL fl_full_clr v=%b occ=%0d c=%b rdy=%b exp 0 0 00 1",
               out_valid, occupancy, out_data[1:0], in_ready);
    end
    in_data = 71'h113;
    tick();
    total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      bad++;
      $display("FAIL fl_drop_in v=%b occ=%0d exp 0 0", out_valid, occupancy);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data[1:0] !== 2'b00) begin
      bad++;
      $display("FAIL fl_quiet v=%b c=%b exp 0 00", out_valid, out_data[1:0]);
    end
    in_valid = 1'b1;
    in_data  = 71'h122;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 71'h122) begin
      bad++;
      $display("FAIL fl_resume v=%b d=%0h exp 1 122", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    resetn = 1'b0;
    #3;
    @(negedge clock);
    resetn = 1'b1;
    tick();
    in_valid  = 1'b1;
    in_data   = 71'h055;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    total++;
    if (stall_cnt4 !== 4'd14) begin
      bad++;
      $display("FAIL sat_14 got=%0d exp=14", stall_cnt4);
    end
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd20) begin
      bad++;
      $display("FAIL sat_20 c4=%0d c16=%0d exp 15 20", stall_cnt4, stall_cnt);
    end
    tick();
    total++;
    if (stall_cnt4 !== 4'd15) begin
      bad++;
      $display("FAIL sat_hold got=%0d exp=15", stall_cnt4);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    in_valid  = 1'b1;
    in_data   = 71'h0AB;
    out_ready = 1'b0;
    tick();
    tick();
    total++;
    if (occupancy !== 2'd2 || stall_cnt === 16'd0) begin
      bad++;
      $display("FAIL ar_pre occ=%0d cnt=%0d exp 2 nonzero", occupancy, stall_cnt);
    end
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 71'd0 || occupancy !== 2'd0 ||
        in_ready !== 1'b0 || stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL ar_now v=%b d=%0h occ=%0d rdy=%b cnt=%0d exp all 0",
               out_valid, out_data, occupancy, in_ready, stall_cnt);
    end
    in_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ar_rel rdy=%b v=%b exp 0 0", in_ready, out_valid);
    end
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ar_edge rdy=%b v=%b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ctrl_mask();
    in_valid  = 1'b1;
    in_data   = 71'h3;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 71'h3) begin
      bad++;
      $display("FAIL cm_live v=%b d=%0h exp 1 3", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data[1:0] !== 2'b00) begin
      bad++;
      $display("FAIL cm_bubble v=%b c=%b exp 0 00", out_valid, out_data[1:0]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturate();
    test_async_reset();
    test_ctrl_mask();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
